// File: rtl/and_gate.sv
// Pipelined bitwise AND of two WIDTH-bit operands with result reductions and a saturating hit counter.
// Define AND_GATE_COMB_EN to replace the STAGES-deep pipeline with a zero-latency combinational path.
module and_gate #(
    parameter int WIDTH  = 1,
    parameter int STAGES = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr,
    output logic [WIDTH-1:0] res,
    output logic             out_valid,
    output logic             res_all,
    output logic             res_any,
    output logic [15:0]      hit_cnt
);

    // Handshake: in_valid qualifies a/b in the cycle it is high; there is no ready, every
    // valid pair is taken. out_valid qualifies res/res_all/res_any; the consumer cannot stall.

`ifdef AND_GATE_COMB_EN

    assign res       = a & b;
    assign res_all   = &res;
    assign res_any   = |res;
    assign out_valid = in_valid;

`else

    logic [WIDTH-1:0] feed_d;
    logic             feed_v;

    generate
        if (STAGES > 1) begin : g_pipe
            logic [WIDTH-1:0] pipe_d [STAGES-1];
            logic [STAGES-2:0] pipe_v;

            // Data registers only load behind a valid bit, so bubble operands never enter.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pipe_v <= '0;
                    for (int k = 0; k < STAGES - 1; k++) begin
                        pipe_d[k] <= '0;
                    end
                end else begin
                    pipe_v[0] <= in_valid;
                    if (in_valid) begin
                        pipe_d[0] <= a & b;
                    end
                    for (int k = 1; k < STAGES - 1; k++) begin
                        pipe_v[k] <= pipe_v[k-1];
                        if (pipe_v[k-1]) begin
                            pipe_d[k] <= pipe_d[k-1];
                        end
                    end
                end
            end

            assign feed_d = pipe_d[STAGES-2];
            assign feed_v = pipe_v[STAGES-2];
        end else begin : g_direct
            assign feed_d = a & b;
            assign feed_v = in_valid;
        end
    endgenerate

    // Output stage is the last pipeline register; it holds through bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res       <= '0;
            res_all   <= 1'b0;
            res_any   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= feed_v;
            if (feed_v) begin
                res     <= feed_d;
                res_all <= &feed_d;
                res_any <= |feed_d;
            end
        end
    end

`endif

    // Counts the edge that closes each cycle showing an all-ones delivered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt <= '0;
        end else if (clr) begin
            hit_cnt <= '0;
        end else if (out_valid && res_all && (hit_cnt != 16'hFFFF)) begin
            hit_cnt <= hit_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_and_gate.sv
// Randomized scoreboard bench for and_gate (WIDTH=8, STAGES=3, default pipelined build).
module tb_and_gate;

    localparam int WIDTH  = 8;
    localparam int STAGES = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             clr = 1'b0;
    logic [WIDTH-1:0] res;
    logic             out_valid;
    logic             res_all;
    logic             res_any;
    logic [15:0]      hit_cnt;

    and_gate #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a), .b(b), .clr(clr),
        .res(res), .out_valid(out_valid), .res_all(res_all), .res_any(res_any),
        .hit_cnt(hit_cnt)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt++;

    // ---------------- scoreboard state ----------------
    logic [WIDTH-1:0] exp_q[$];
    int               due_q[$];
    logic [WIDTH-1:0] last_res = '0;
    logic [15:0]      exp_hit = '0;
    int               vectors = 0;
    int               errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, edge_cnt, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; inputs are sampled on the next one.
    task automatic issue(input bit v, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                         input bit c);
        in_valid = v;
        a        = v ? x : 'x;
        b        = v ? y : 'x;
        clr      = c;
        if (v && rst_n) begin
            exp_q.push_back(x & y);
            due_q.push_back(edge_cnt + STAGES);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(1'b0, '0, '0, 1'b0);
    endtask

    // Reset drops everything in flight; outputs must clear without waiting for a clock.
    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        clr = 1'b0;
        exp_q.delete();
        due_q.delete();
        last_res = '0;
        exp_hit = '0;
        #1;
        check("async_rst_res", 64'(res), 64'(0));
        check("async_rst_valid", 64'(out_valid), 64'(0));
        check("async_rst_all_any", 64'({res_all, res_any}), 64'(0));
        check("async_rst_hit", 64'(hit_cnt), 64'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_valid", 64'(out_valid), 64'(0));
            check("rst_res", 64'(res), 64'(0));
            check("rst_hit", 64'(hit_cnt), 64'(0));
        end else begin
            logic [WIDTH-1:0] e;
            bit deliver;
            check("hit_cnt", 64'(hit_cnt), 64'(exp_hit));
            deliver = (due_q.size() > 0) && (due_q[0] == edge_cnt);
            e = last_res;
            if (deliver) begin
                e = exp_q.pop_front();
                void'(due_q.pop_front());
                last_res = e;
            end
            check("out_valid", 64'(out_valid), 64'(deliver));
            check("res", 64'(res), 64'(e));
            check("res_all", 64'(res_all), 64'(e == {WIDTH{1'b1}}));
            check("res_any", 64'(res_any), 64'(e != '0));
            if (clr)
                exp_hit = '0;
            else if (deliver && (e == {WIDTH{1'b1}}) && (exp_hit != 16'hFFFF))
                exp_hit = exp_hit + 16'd1;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Back-to-back throughput, then a 1,0,1 bubble pattern.
        issue(1'b1, 8'hA5, 8'h0F, 1'b0);
        issue(1'b1, 8'hFF, 8'hFF, 1'b0);
        idle(4);
        issue(1'b1, 8'h3C, 8'hF0, 1'b0);
        issue(1'b0, '0, '0, 1'b0);
        issue(1'b1, 8'h81, 8'hC3, 1'b0);
        idle(4);

        // Per-bit truth table on alternating patterns.
        issue(1'b1, 8'h00, 8'h00, 1'b0);
        issue(1'b1, 8'hAA, 8'h00, 1'b0);
        issue(1'b1, 8'h00, 8'h55, 1'b0);
        issue(1'b1, 8'hAA, 8'hAA, 1'b0);
        issue(1'b1, 8'hAA, 8'h55, 1'b0);
        idle(4);

        // Random traffic with occasional all-ones pairs and clears.
        for (int i = 0; i < 2000; i++) begin
            logic [WIDTH-1:0] x, y;
            x = WIDTH'($urandom);
            y = WIDTH'($urandom);
            if ($urandom_range(0, 5) == 0) begin
                x = '1;
                y = '1;
            end
            issue($urandom_range(0, 3) != 0, x, y, $urandom_range(0, 49) == 0);
        end

        // Reset with a pair still in flight.
        issue(1'b1, 8'hFF, 8'hFF, 1'b0);
        issue(1'b0, '0, '0, 1'b0);
        do_reset();
        idle(STAGES + 3);

        // Drive the counter into saturation, hold it there, then clear during a hit.
        for (int i = 0; i < 65540; i++) issue(1'b1, 8'hFF, 8'hFF, 1'b0);
        check("hit_saturated", 64'(hit_cnt), 64'(16'hFFFF));
        issue(1'b1, 8'hFF, 8'hFF, 1'b1);
        issue(1'b1, 8'hFF, 8'hFF, 1'b0);
        issue(1'b1, 8'hFF, 8'hFF, 1'b0);
        idle(STAGES + 3);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/and_gate.md
AND_GATE -- requirements
Module: and_gate

Interface
REQ-001 Parameter WIDTH, default 1: operand and result width in bits, legal range 1..64.
REQ-002 Parameter STAGES, default 1: pipeline latency in clock cycles, legal range 1..4.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  marks a and b as a valid operand pair this cycle.
REQ-006 a  input  WIDTH  first operand.
REQ-007 b  input  WIDTH  second operand.
REQ-008 clr  input  1  synchronous clear of hit_cnt.
REQ-009 res  output  WIDTH  bitwise AND result.
REQ-010 out_valid  output  1  res, res_all and res_any carry a valid result.
REQ-011 res_all  output  1  reduction AND of the delivered res.
REQ-012 res_any  output  1  reduction OR of the delivered res.
REQ-013 hit_cnt  output  16  count of delivered results with res_all=1.

Function
REQ-014 The result for each operand pair SHALL be res = a & b, bit by bit, with no carry or interaction between bits.
REQ-015 A pair accepted with in_valid=1 at edge N SHALL appear on res with out_valid=1 after edge N+STAGES-1, so STAGES=1 gives registered output one edge later.
REQ-016 The pipeline SHALL accept a new pair every cycle and SHALL have no backpressure or stall.
REQ-017 The valid bit SHALL travel through the pipeline alongside the data.
REQ-018 A cycle with in_valid=0 SHALL produce a bubble: out_valid=0 STAGES cycles later.
REQ-019 While out_valid=0, res, res_all and res_any SHALL hold their last valid values.
REQ-020 res_all SHALL be 1 only if every bit of res is 1; for WIDTH=1, res_all = res_any = res.
REQ-021 hit_cnt SHALL increment by 1 on each cycle where out_valid=1 and res_all=1.
REQ-022 hit_cnt SHALL saturate at 16'hFFFF and SHALL not wrap.
REQ-023 If clr=1 and an increment occur in the same cycle, clr SHALL win and hit_cnt SHALL become 0.
REQ-024 X or Z bits on a or b while in_valid=0 SHALL NOT affect any output.

Reset
REQ-025 Asserting rst_n=0 SHALL immediately and asynchronously clear all pipeline data and valid bits, res, res_all, res_any, out_valid and hit_cnt to 0.
REQ-026 Pairs in flight at reset SHALL be discarded and never delivered.
REQ-027 The first pair accepted after rst_n deasserts SHALL follow the normal latency in REQ-015.

Configuration
REQ-028 With macro AND_GATE_COMB_EN defined, res, res_all and res_any SHALL be purely combinational from a and b with zero latency, and out_valid SHALL equal in_valid.
REQ-029 With AND_GATE_COMB_EN defined, STAGES SHALL be ignored and hit_cnt SHALL count on each clock edge where in_valid=1 and the AND result is all ones.
REQ-030 With AND_GATE_COMB_EN defined, hit_cnt SHALL keep its reset and clr behaviour.
REQ-031 Without AND_GATE_COMB_EN, the registered pipeline of REQ-015 SHALL apply.

Verification
REQ-032 Truth table, WIDTH=1, STAGES=1: pairs a,b = 00, 10, 01, 11 on consecutive cycles -> res = 0, 0, 0, 1 one cycle later each, with hit_cnt=1 at the end.
REQ-033 Throughput, WIDTH=8, STAGES=3: back-to-back pairs A5&0F then FF&FF -> res=05 then FF on consecutive cycles after a 3-cycle latency, res_any=1 for both, res_all=0 then 1.
REQ-034 Bubble, STAGES=2: in_valid pattern 1,0,1 -> out_valid pattern 1,0,1 delayed 2 cycles, with res held during the bubble.
REQ-035 Reset mid-flight, STAGES=4: pull rst_n low two cycles after issuing 11 -> all outputs 0 at once and no result delivered after release.
REQ-036 Counter: preload 16'hFFFE, then three all-ones results -> hit_cnt ends at FFFF; clr asserted together with a hit -> 0.
REQ-037 With AND_GATE_COMB_EN defined: a=1, b=1 -> res=1 in the same cycle, with out_valid following in_valid.
